// File: rtl/maxnet_pkg.sv
// Shared definitions for the MaxNet winner-take-all engine: FSM encoding and
// result status codes.
package maxnet_pkg;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        STATUS_WIN     = 2'd0,
        STATUS_NONE    = 2'd1,
        STATUS_TIMEOUT = 2'd2
    } status_e;

endpackage

// File: rtl/maxnet_neuron_update.sv
// One neuron's mutual-inhibition step: a_next = max(a - (eps*(S-a)) >> FRAC, 0).
// Purely combinational; the inhibition term is kept at full width so it never wraps.
module maxnet_neuron_update #(
    parameter int W    = 32,
    parameter int FRAC = 8,
    parameter int SW   = 34
) (
    input  logic [W-1:0]    a_i,
    input  logic [SW-1:0]   sum,
    input  logic [FRAC-1:0] eps,
    output logic [W-1:0]    a_next
);

    logic [SW-1:0]      others_s;
    logic [SW+FRAC-1:0] prod_s;
    logic [SW-1:0]      inh_s;
    logic [SW-1:0]      a_ext_s;

    assign a_ext_s  = {{(SW-W){1'b0}}, a_i};
    assign others_s = sum - a_ext_s;
    assign prod_s   = {{SW{1'b0}}, eps} * {{FRAC{1'b0}}, others_s};
    assign inh_s    = prod_s[SW+FRAC-1:FRAC];

    // Clamp at zero; when a > inh the inhibition fits in W bits
    always_comb begin
        if (a_ext_s > inh_s) begin
            a_next = a_i - inh_s[W-1:0];
        end else begin
            a_next = '0;
        end
    end

endmodule

// File: rtl/maxnet_engine.sv
// MaxNet winner-take-all engine: streams in N activations, iterates mutual
// inhibition one step per cycle, and returns the survivor over valid/ready.
module maxnet_engine
    import maxnet_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int FRAC     = 8,
    parameter int MAX_ITER = 255,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W   = $clog2(MAX_ITER + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [FRAC-1:0]  epsilon,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] winner_idx,
    output logic [W-1:0]     winner_val,
    output logic [CNT_W-1:0] iter_count,
    output logic [1:0]       status
);

    localparam int SW   = W + IDX_W;
    localparam int NZ_W = $clog2(N + 1);

    localparam logic [NZ_W-1:0]  NZ_ONE    = {{(NZ_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_ITER);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] load_idx_q, load_idx_d;
    logic [FRAC-1:0]  eps_q, eps_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] widx_q, widx_d;
    logic [W-1:0]     wval_q, wval_d;
    status_e          status_q, status_d;
    logic [W-1:0]     a_q [N];
    logic [W-1:0]     a_d [N];
    logic [W-1:0]     x_q [N];
    logic [W-1:0]     x_d [N];

    logic [W-1:0]     a_upd_s [N];
    logic [SW-1:0]    sum_s;
    logic [NZ_W-1:0]  nz_cnt_s;
    logic [IDX_W-1:0] first_nz_s;
    logic [IDX_W-1:0] argmax_s;
    logic [W-1:0]     best_val_s;

    // Sum, survivor count and lowest-index nonzero neuron from registered activations
    always_comb begin
        sum_s      = '0;
        nz_cnt_s   = '0;
        first_nz_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum_s = sum_s + SW'(a_q[i]);
            if (a_q[i] != '0) begin
                nz_cnt_s   = nz_cnt_s + NZ_ONE;
                first_nz_s = IDX_W'(i);
            end else begin
                nz_cnt_s   = nz_cnt_s;
            end
        end
    end

    // Argmax with strict compare so ties resolve to the lowest index
    always_comb begin
        best_val_s = a_q[0];
        argmax_s   = '0;
        for (int i = 1; i < N; i++) begin
            if (a_q[i] > best_val_s) begin
                best_val_s = a_q[i];
                argmax_s   = IDX_W'(i);
            end else begin
                best_val_s = best_val_s;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_neuron
        maxnet_neuron_update #(
            .W    (W),
            .FRAC (FRAC),
            .SW   (SW)
        ) u_update (
            .a_i    (a_q[g]),
            .sum    (sum_s),
            .eps    (eps_q),
            .a_next (a_upd_s[g])
        );
    end

    // Next-state logic for load, iteration and result hand-off
    always_comb begin
        state_d     = state_q;
        load_idx_d  = load_idx_q;
        eps_d       = eps_q;
        iter_d      = iter_q;
        out_valid_d = out_valid_q;
        widx_d      = widx_q;
        wval_d      = wval_q;
        status_d    = status_q;
        for (int i = 0; i < N; i++) begin
            a_d[i] = a_q[i];
            x_d[i] = x_q[i];
        end

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        if (IDX_W'(i) == load_idx_q) begin
                            a_d[i] = in_data;
                            x_d[i] = in_data;
                        end else begin
                            a_d[i] = a_q[i];
                        end
                    end
                    if (load_idx_q == IDX_LAST) begin
                        load_idx_d = '0;
                        eps_d      = epsilon;
                        iter_d     = '0;
                        state_d    = ST_ITER;
                    end else begin
                        load_idx_d = load_idx_q + IDX_ONE;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_ITER: begin
                if (nz_cnt_s == NZ_ONE) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    widx_d      = first_nz_s;
                    wval_d      = x_q[first_nz_s];
                    status_d    = STATUS_WIN;
                end else if (nz_cnt_s == '0) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    widx_d      = '0;
                    wval_d      = x_q[0];
                    status_d    = STATUS_NONE;
                end else if (iter_q == CNT_LIMIT) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    widx_d      = argmax_s;
                    wval_d      = x_q[argmax_s];
                    status_d    = STATUS_TIMEOUT;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        a_d[i] = a_upd_s[i];
                    end
                    iter_d = iter_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_LOAD;
                load_idx_d  = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LOAD;
            load_idx_q  <= '0;
            eps_q       <= '0;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
            widx_q      <= '0;
            wval_q      <= '0;
            status_q    <= STATUS_WIN;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            load_idx_q  <= load_idx_d;
            eps_q       <= eps_d;
            iter_q      <= iter_d;
            out_valid_q <= out_valid_d;
            widx_q      <= widx_d;
            wval_q      <= wval_d;
            status_q    <= status_d;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= a_d[i];
                x_q[i] <= x_d[i];
            end
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign out_valid  = out_valid_q;
    assign winner_idx = widx_q;
    assign winner_val = wval_q;
    assign iter_count = iter_q;
    assign status     = status_q;

endmodule

// File: tb/tb_maxnet_engine.sv
// Scoreboard bench for maxnet_engine (N=4, W=16, FRAC=8, MAX_ITER=16): expected
// results are queued at load time and compared when out_valid appears.
module tb_maxnet_engine;

    localparam int N        = 4;
    localparam int W        = 16;
    localparam int FRAC     = 8;
    localparam int MAX_ITER = 16;
    localparam int BUDGET   = 100;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] val;
        logic [4:0]  iter;
        logic [1:0]  st;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic [7:0]  epsilon = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  winner_idx;
    logic [15:0] winner_val;
    logic [4:0]  iter_count;
    logic [1:0]  status;

    int   n_run  = 0;
    int   n_fail = 0;
    res_t sb[$];

    maxnet_engine #(
        .N(N), .W(W), .FRAC(FRAC), .MAX_ITER(MAX_ITER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .epsilon    (epsilon),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .winner_idx (winner_idx),
        .winner_val (winner_val),
        .iter_count (iter_count),
        .status     (status)
    );

    always #5 clk = ~clk;

    function automatic res_t observed();
        return {winner_idx, winner_val, iter_count, status};
    endfunction

    // Independent behavioural reference of the MaxNet iteration
    function automatic res_t model(input logic [15:0] v[4], input logic [7:0] eps);
        longint a[4];
        longint na[4];
        longint s, inh;
        int     nz, bi;
        res_t   r;
        r = '0;
        for (int i = 0; i < 4; i++) a[i] = longint'(v[i]);
        for (int it = 0; it <= MAX_ITER; it++) begin
            nz = 0;
            bi = 0;
            for (int i = 3; i >= 0; i--) if (a[i] != 0) begin nz++; bi = i; end
            if (nz == 1) return {2'(bi), v[bi], 5'(it), 2'd0};
            if (nz == 0) return {2'd0, v[0], 5'(it), 2'd1};
            if (it == MAX_ITER) begin
                bi = 0;
                for (int i = 1; i < 4; i++) if (a[i] > a[bi]) bi = i;
                return {2'(bi), v[bi], 5'(it), 2'd2};
            end
            s = 0;
            for (int i = 0; i < 4; i++) s += a[i];
            for (int i = 0; i < 4; i++) begin
                inh   = (longint'(eps) * (s - a[i])) >> FRAC;
                na[i] = (a[i] > inh) ? a[i] - inh : 0;
            end
            a = na;
        end
        return r;
    endfunction

    task automatic load(input logic [15:0] v0, v1, v2, v3, input logic [7:0] eps);
        logic [15:0] v[4];
        v = '{v0, v1, v2, v3};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = v[k];
            epsilon  = eps;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        epsilon  = 8'hFF;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_run++;
        if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, 25'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%b ir=%b res=%h, want ov=0 ir=1 res=0",
                     out_valid, in_ready, observed());
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        int   cyc;
        res_t exp;
        sb.push_back({2'd2, 16'd7, 5'd0, 2'd0});
        n_run++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_in_ready: got %b want 1", in_ready);
        end
        load(16'd0, 16'd0, 16'd7, 16'd0, 8'h20);
        wait_out(cyc);
        n_run++;
        if (cyc != 1) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles want 1", cyc);
        end
        exp = sb.pop_front();
        n_run++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL single_result: got %h want %h", observed(), exp);
        end
        handshake();
        n_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_release: got ov/ir=%b%b want 01", out_valid, in_ready);
        end
    endtask

    task automatic test_two();
        int   cyc;
        res_t exp;
        sb.push_back({2'd3, 16'd200, 5'd1, 2'd0});
        load(16'd100, 16'd0, 16'd0, 16'd200, 8'h80);
        wait_out(cyc);
        exp = sb.pop_front();
        n_run++;
        if (cyc >= BUDGET || observed() !== exp) begin
            n_fail++;
            $display("FAIL two_result: got %h (cyc %0d) want %h", observed(), cyc, exp);
        end
        handshake();
    endtask

    task automatic test_timeout();
        int   cyc;
        res_t exp;
        sb.push_back({2'd0, 16'd50, 5'd16, 2'd2});
        load(16'd50, 16'd50, 16'd0, 16'd0, 8'h80);
        wait_out(cyc);
        exp = sb.pop_front();
        n_run++;
        if (cyc >= BUDGET || observed() !== exp) begin
            n_fail++;
            $display("FAIL timeout_result: got %h (cyc %0d) want %h", observed(), cyc, exp);
        end
        handshake();
        // epsilon=0 never converges; tie on the largest resolves to index 1
        sb.push_back({2'd1, 16'd9, 5'd16, 2'd2});
        load(16'd3, 16'd9, 16'd9, 16'd1, 8'h00);
        wait_out(cyc);
        exp = sb.pop_front();
        n_run++;
        if (cyc >= BUDGET || observed() !== exp) begin
            n_fail++;
            $display("FAIL eps0_timeout: got %h (cyc %0d) want %h", observed(), cyc, exp);
        end
        handshake();
    endtask

    task automatic test_zero();
        int   cyc;
        res_t exp;
        sb.push_back({2'd0, 16'd0, 5'd0, 2'd1});
        out_ready = 1'b1;
        load(16'd0, 16'd0, 16'd0, 16'd0, 8'h40);
        n_run++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_early_valid: got %b want 0", out_valid);
        end
        wait_out(cyc);
        exp = sb.pop_front();
        n_run++;
        if (cyc >= BUDGET || observed() !== exp) begin
            n_fail++;
            $display("FAIL zero_result: got %h (cyc %0d) want %h", observed(), cyc, exp);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL zero_release: got ov/ir=%b%b want 01", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int   cyc;
        int   bad;
        res_t exp;
        res_t snap;
        sb.push_back({2'd3, 16'd200, 5'd1, 2'd0});
        load(16'd100, 16'd0, 16'd0, 16'd200, 8'h80);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        n_run++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_iter: got %b want 0", in_ready);
        end
        wait_out(cyc);
        snap = observed();
        bad  = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || observed() !== snap) bad++;
        end
        in_valid = 1'b0;
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
        end
        exp = sb.pop_front();
        n_run++;
        if (cyc >= BUDGET || observed() !== exp) begin
            n_fail++;
            $display("FAIL bp_result: got %h (cyc %0d) want %h", observed(), cyc, exp);
        end
        handshake();
        sb.push_back({2'd2, 16'd7, 5'd0, 2'd0});
        load(16'd0, 16'd0, 16'd7, 16'd0, 8'h20);
        wait_out(cyc);
        exp = sb.pop_front();
        n_run++;
        if (cyc >= BUDGET || observed() !== exp) begin
            n_fail++;
            $display("FAIL bp_reload: got %h (cyc %0d) want %h", observed(), cyc, exp);
        end
        handshake();
    endtask

    task automatic test_reset_mid_iter();
        int   cyc;
        res_t exp;
        load(16'd50, 16'd50, 16'd0, 16'd0, 8'h80);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_run++;
        if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, 25'd0}) begin
            n_fail++;
            $display("FAIL midreset_state: got ov=%b ir=%b res=%h, want ov=0 ir=1 res=0",
                     out_valid, in_ready, observed());
        end
        @(negedge clk);
        rst = 1'b1;
        sb.push_back({2'd3, 16'd200, 5'd1, 2'd0});
        load(16'd100, 16'd0, 16'd0, 16'd200, 8'h80);
        wait_out(cyc);
        exp = sb.pop_front();
        n_run++;
        if (cyc >= BUDGET || observed() !== exp) begin
            n_fail++;
            $display("FAIL midreset_after: got %h (cyc %0d) want %h", observed(), cyc, exp);
        end
        handshake();
    endtask

    task automatic test_random();
        int          cyc;
        res_t        exp;
        logic [15:0] v[4];
        logic [7:0]  eps;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 4; i++)
                v[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 1000));
            eps = 8'($urandom_range(0, 255));
            sb.push_back(model(v, eps));
            load(v[0], v[1], v[2], v[3], eps);
            wait_out(cyc);
            exp = sb.pop_front();
            n_run++;
            if (cyc >= BUDGET || observed() !== exp) begin
                n_fail++;
                $display("FAIL random_%0d: got %h (cyc %0d) want %h", t, observed(), cyc, exp);
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_timeout();
        test_zero();
        test_backpressure();
        test_reset_mid_iter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
